// File: rtl/rl_pkg.sv
// Types and defaults shared by the RL agent blocks: the selector FSM encoding,
// the randomizer seed and the Q-value width.
package rl_pkg;

    typedef enum logic [2:0] {
        S_SEED,
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_OUT
    } sel_state_e;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int          DEFAULT_Q_W  = 16;

endpackage

// File: rtl/q_argmax.sv
// Running signed maximum over Q-values streamed in index order.
// Ties keep the earlier (lower) index because only a strictly greater value replaces the best.
module q_argmax
    import rl_pkg::*;
#(
    parameter int ACT_W = 2,
    parameter int Q_W   = DEFAULT_Q_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             vld,
    input  logic [ACT_W-1:0] idx,
    input  logic [Q_W-1:0]   q_data,
    output logic [ACT_W-1:0] best_idx_next
);

    logic signed [Q_W-1:0] best_q_q, best_q_d;
    logic [ACT_W-1:0]      best_idx_q, best_idx_d;
    logic signed [Q_W-1:0] data_s;

    assign data_s        = q_data;
    assign best_idx_next = best_idx_d;

    always_comb begin
        best_q_d   = best_q_q;
        best_idx_d = best_idx_q;
        if (clr) begin
            best_q_d   = '0;
            best_idx_d = '0;
        end else if (vld && ((idx == '0) || (data_s > best_q_q))) begin
            // Index 0 seeds the search regardless of the cleared value.
            best_q_d   = data_s;
            best_idx_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q_q   <= '0;
            best_idx_q <= '0;
        end else begin
            best_q_q   <= best_q_d;
            best_idx_q <= best_idx_d;
        end
    end

endmodule

// File: rtl/eps_greedy_selector.sv
// Epsilon-greedy action selector: scans the Q-values of the current state, then emits
// either the argmax action or a random one, chosen by comparing a captured random word to epsilon.
module eps_greedy_selector
    import rl_pkg::*;
#(
    parameter int          NUM_ACTIONS = 4,
    parameter int          ACT_W       = 2,
    parameter int          Q_W         = DEFAULT_Q_W,
    parameter logic [15:0] SEED        = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      epsilon,
    output logic             q_rd_en,
    output logic [ACT_W-1:0] q_addr,
    input  logic [Q_W-1:0]   q_data,
    input  logic [15:0]      rnd,
    output logic             rnd_start,
    output logic [15:0]      rnd_ic,
    output logic             act_valid,
    input  logic             act_ready,
    output logic [ACT_W-1:0] action,
    output logic             explored
);

    sel_state_e       state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             q_rd_en_q, q_rd_en_d;
    logic [ACT_W-1:0] q_addr_q, q_addr_d;
    logic             rnd_start_q, rnd_start_d;
    logic             act_valid_q, act_valid_d;
    logic [ACT_W-1:0] action_q, action_d;
    logic             explored_q, explored_d;
    logic [15:0]      e_reg_q, e_reg_d;
    logic [15:0]      r_exp_q, r_exp_d;
    logic             rd_pend_q, rd_pend_d;
    logic [ACT_W-1:0] rd_idx_q, rd_idx_d;
    logic             am_clr;
    logic [ACT_W-1:0] best_idx_next;

    localparam logic [ACT_W-1:0] LAST_ADDR = ACT_W'(NUM_ACTIONS - 1);

    q_argmax #(
        .ACT_W (ACT_W),
        .Q_W   (Q_W)
    ) u_argmax (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (am_clr),
        .vld           (rd_pend_q),
        .idx           (rd_idx_q),
        .q_data        (q_data),
        .best_idx_next (best_idx_next)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        q_rd_en_d   = q_rd_en_q;
        q_addr_d    = q_addr_q;
        rnd_start_d = rnd_start_q;
        act_valid_d = act_valid_q;
        action_d    = action_q;
        explored_d  = explored_q;
        e_reg_d     = e_reg_q;
        r_exp_d     = r_exp_q;
        am_clr      = 1'b0;
        // Read data returns one cycle after the strobe, so track which index is in flight.
        rd_pend_d   = q_rd_en_q;
        rd_idx_d    = q_addr_q;

        case (state_q)
            S_SEED: begin
                if (!rnd_start_q) begin
                    rnd_start_d = 1'b1;
                end else begin
                    rnd_start_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    q_rd_en_d   = 1'b1;
                    q_addr_d    = '0;
                    e_reg_d     = epsilon;
                    r_exp_d     = rnd;
                    am_clr      = 1'b1;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (q_addr_q == LAST_ADDR) begin
                    q_rd_en_d = 1'b0;
                    q_addr_d  = '0;
                    state_d   = S_DRAIN;
                end else begin
                    q_addr_d = q_addr_q + ACT_W'(1);
                end
            end
            S_DRAIN: begin
                // best_idx_next already includes the last Q-value arriving this cycle.
                explored_d  = (r_exp_q < e_reg_q);
                action_d    = explored_d ? rnd[ACT_W-1:0] : best_idx_next;
                act_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (act_ready) begin
                    act_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_SEED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SEED;
            req_ready_q <= 1'b0;
            q_rd_en_q   <= 1'b0;
            q_addr_q    <= '0;
            rnd_start_q <= 1'b0;
            act_valid_q <= 1'b0;
            action_q    <= '0;
            explored_q  <= 1'b0;
            e_reg_q     <= '0;
            r_exp_q     <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            q_rd_en_q   <= q_rd_en_d;
            q_addr_q    <= q_addr_d;
            rnd_start_q <= rnd_start_d;
            act_valid_q <= act_valid_d;
            action_q    <= action_d;
            explored_q  <= explored_d;
            e_reg_q     <= e_reg_d;
            r_exp_q     <= r_exp_d;
            rd_pend_q   <= rd_pend_d;
            rd_idx_q    <= rd_idx_d;
        end
    end

    assign req_ready = req_ready_q;
    assign q_rd_en   = q_rd_en_q;
    assign q_addr    = q_addr_q;
    assign rnd_start = rnd_start_q;
    assign rnd_ic    = SEED;
    assign act_valid = act_valid_q;
    assign action    = action_q;
    assign explored  = explored_q;

endmodule

// File: tb/tb_eps_greedy_selector.sv
// Bench for eps_greedy_selector: LFSR randomizer and Q-table models around the DUT,
// directed corner cases plus randomized transactions checked against a reference model.
module tb_eps_greedy_selector;

    localparam int N     = 4;
    localparam int ACT_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] epsilon = '0;
    logic        q_rd_en;
    logic [1:0]  q_addr;
    logic [15:0] q_data = '0;
    logic [15:0] rnd;
    logic        rnd_start;
    logic [15:0] rnd_ic;
    logic        act_valid;
    logic        act_ready = 1'b0;
    logic [1:0]  action;
    logic        explored;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int txn   = 0;

    logic signed [15:0] qtab [N];
    logic [15:0]        lfsr = 16'h0001;

    eps_greedy_selector #(
        .NUM_ACTIONS (N),
        .ACT_W       (ACT_W),
        .Q_W         (16),
        .SEED        (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .epsilon   (epsilon),
        .q_rd_en   (q_rd_en),
        .q_addr    (q_addr),
        .q_data    (q_data),
        .rnd       (rnd),
        .rnd_start (rnd_start),
        .rnd_ic    (rnd_ic),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .action    (action),
        .explored  (explored)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Randomizer: seed load on rnd_start, otherwise one Fibonacci shift per cycle.
    always @(posedge clk) begin
        if (rnd_start) lfsr <= rnd_ic;
        else           lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign rnd = lfsr;

    // Q-table: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (q_rd_en) q_data <= qtab[q_addr];
        else         q_data <= 16'($urandom);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_argmax();
        int best = 0;
        for (int i = 1; i < N; i++)
            if (qtab[i] > qtab[best]) best = i;
        return best;
    endfunction

    task automatic check_reset_outputs();
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_q_rd_en",   {31'd0, q_rd_en},   32'd0);
        check_val("rst_q_addr",    {30'd0, q_addr},    32'd0);
        check_val("rst_act_valid", {31'd0, act_valid}, 32'd0);
        check_val("rst_action",    {30'd0, action},    32'd0);
        check_val("rst_explored",  {31'd0, explored},  32'd0);
        check_val("rst_rnd_start", {31'd0, rnd_start}, 32'd0);
    endtask

    // Called at a negedge; asserts reset, checks outputs, releases and checks the reseed.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) begin
            @(negedge clk);
            check_val("rst_hold_act_valid", {31'd0, act_valid}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_val("seed_rnd_start_hi", {31'd0, rnd_start}, 32'd1);
        check_val("seed_rnd_ic",       {16'd0, rnd_ic},    32'hACE1);
        check_val("seed_req_ready_lo", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check_val("seed_rnd_start_lo", {31'd0, rnd_start}, 32'd0);
        check_val("seed_rnd_q",        {16'd0, rnd},       32'hACE1);
        check_val("seed_req_ready_hi", {31'd0, req_ready}, 32'd1);
    endtask

    // Waits (bounded) for req_ready, then presents a request at a negedge.
    task automatic issue_req(input logic [15:0] eps, output int t0, output logic [15:0] r_exp,
                             output bit ok);
        int waited = 0;
        ok = 1'b1;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check_val("req_ready_timeout", 32'd0, 32'd1);
            ok = 1'b0;
            return;
        end
        req_valid = 1'b1;
        epsilon   = eps;
        t0        = cyc;
        r_exp     = rnd;
    endtask

    task automatic run_txn(input logic [15:0] eps, input int hold);
        int          t0;
        logic [15:0] r_exp, r_dec;
        bit          ok;
        logic        exp_expl;
        int          exp_act;
        issue_req(eps, t0, r_exp, ok);
        if (!ok) return;
        r_dec = '0;
        for (int k = 1; k <= N + 2; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            check_val("scan_rd_en", {31'd0, q_rd_en}, {31'd0, (k <= N)});
            if (k <= N) check_val("scan_addr", {30'd0, q_addr}, 32'(k - 1));
            if (k == N + 1) r_dec = rnd;
            if (k <= N + 1) check_val("early_act_valid", {31'd0, act_valid}, 32'd0);
            check_val("busy_req_ready", {31'd0, req_ready}, 32'd0);
        end
        check_val("act_valid_latency", {31'd0, act_valid}, 32'd1);
        exp_expl = (r_exp < eps);
        exp_act  = exp_expl ? int'(r_dec[1:0]) : ref_argmax();
        check_val("explored", {31'd0, explored}, {31'd0, exp_expl});
        check_val("action",   {30'd0, action},   32'(exp_act));
        $display("txn %0d eps=%04h r_exp=%04h q={%0d,%0d,%0d,%0d} action=%0d explored=%0d hold=%0d",
                 txn, eps, r_exp, qtab[0], qtab[1], qtab[2], qtab[3], action, explored, hold);
        txn++;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("bp_act_valid", {31'd0, act_valid}, 32'd1);
            check_val("bp_action",    {30'd0, action},    32'(exp_act));
            check_val("bp_explored",  {31'd0, explored},  {31'd0, exp_expl});
            check_val("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        act_ready = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        check_val("post_act_valid", {31'd0, act_valid}, 32'd0);
        check_val("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic set_q(input int a, input int b, input int c, input int d);
        qtab[0] = 16'(a);
        qtab[1] = 16'(b);
        qtab[2] = 16'(c);
        qtab[3] = 16'(d);
    endtask

    initial begin
        int          t0;
        logic [15:0] r_exp;
        bit          ok;
        set_q(0, 0, 0, 0);
        @(negedge clk);
        do_reset();

        // Greedy, tie resolves low
        set_q(10, -5, 30, 30);
        run_txn(16'h0000, 0);
        // Signed compares
        set_q(-100, -3, -50, -7);
        run_txn(16'h0000, 0);
        set_q(32767, -32768, 0, 0);
        run_txn(16'h0000, 0);
        // Forced explore then the same with epsilon 0
        set_q(1, 2, 3, 4);
        run_txn(16'hFFFF, 0);
        run_txn(16'h0000, 0);
        // Backpressure
        set_q(5, 9, -1, 9);
        run_txn(16'h8000, 10);

        // Mid-scan reset at T+2
        issue_req(16'h0000, t0, r_exp, ok);
        if (ok) begin
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            do_reset();
        end
        set_q(-1, -2, 7, 3);
        run_txn(16'h0000, 0);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 3);
            logic [15:0] e;
            for (int j = 0; j < N; j++)
                qtab[j] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            case (sel)
                0:       e = 16'h0000;
                1:       e = 16'hFFFF;
                default: e = 16'($urandom);
            endcase
            run_txn(e, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eps_greedy_selector.md
# eps_greedy_selector

Epsilon-greedy action selector for the RL agent. It sits directly downstream of the 16-bit LFSR randomizer and also drives that randomizer's seed load. On each request it scans the Q-values of the current state and picks either the greedy (argmax) action or, with probability epsilon/65536, a random action. The chosen action goes out through a valid/ready handshake.

## Interface
- NUM_ACTIONS, 4, number of actions; must be a power of 2, at least 2
- ACT_W, 2, log2(NUM_ACTIONS)
- Q_W, 16, Q-value width, two's-complement signed
- SEED, 16'hACE1, nonzero LFSR seed driven on rnd_ic
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req_valid  in  1  request to select an action for the current state
- req_ready  out  1  high only in IDLE
- epsilon  in  16  exploration threshold, unsigned; sampled at request accept
- q_rd_en  out  1  Q-table read strobe
- q_addr  out  ACT_W  action index being read
- q_data  in  Q_W  Q-table read data, valid 1 cycle after q_rd_en
- rnd  in  16  randomizer output q; advances one shift per cycle
- rnd_start  out  1  randomizer start (seed load)
- rnd_ic  out  16  randomizer seed; constant SEED
- act_valid  out  1  action result valid
- act_ready  in  1  consumer accepts result
- action  out  ACT_W  selected action
- explored  out  1  1 = random action, 0 = greedy action

## Operation
- FSM states: SEED, IDLE, SCAN, DRAIN, OUT.
- SEED: entered on reset. rnd_start = 1 for exactly one cycle, so the randomizer loads SEED on that edge. Next state is IDLE.
- IDLE: req_ready = 1. On req_valid & req_ready, capture the following and go to SCAN:
  - e_reg = epsilon
  - r_exp = rnd
  - clear best_q and best_idx
- SCAN: q_rd_en = 1 with q_addr = 0, 1, …, NUM_ACTIONS-1 on consecutive cycles. After the last address, go to DRAIN.
- Argmax: each returned q_data is compared as signed against best_q.
  - Index 0 loads unconditionally.
  - Later indices replace the best only on strictly greater, so ties resolve to the lowest index.
- DRAIN: the final q_data is folded in. Decision:
  - explored = (r_exp < e_reg), unsigned compare.
  - If explored: action = rnd[ACT_W-1:0] sampled this cycle.
  - Else: action = best_idx.
  - Then go to OUT.
- OUT: act_valid = 1. action and explored stay stable until act_ready. On act_valid & act_ready, go to IDLE.
- Epsilon boundaries:
  - epsilon = 0 never explores.
  - epsilon = 16'hFFFF explores unless r_exp = 16'hFFFF.
- New requests are not accepted outside IDLE; req_valid is ignored there.
- Reset mid-operation: the scan is abandoned, no act_valid is produced, and the FSM returns to SEED and reseeds the randomizer.

## Timing
- Reset values: req_ready 0, q_rd_en 0, q_addr 0, act_valid 0, action 0, explored 0, rnd_start 0.
- Reset release: rnd_start = 1 in the first cycle after release; req_ready = 1 in the second cycle.
- Request accepted in cycle T:
  - q_rd_en is high in cycles T+1 … T+N, with q_addr = cycle − (T+1).
  - q_data is consumed in cycles T+2 … T+N+1.
  - The decision is registered at the end of T+N+1.
  - act_valid = 1 from cycle T+N+2.
- Minimum request-to-request period is N+3 cycles when act_ready is held high.
- Back-to-back: act_valid & act_ready in cycle U gives req_ready = 1 in cycle U+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package rl_pkg holds:
  - the FSM state enum (SEED, IDLE, SCAN, DRAIN, OUT)
  - the default SEED constant
  - the default Q_W
- The package is shared with the Q-table and reward blocks.
- One sub-module, q_argmax, contains the running signed max, its index, the clear/load/update control, and the tie-to-lowest rule.
- The FSM, epsilon compare and output registers stay in the top level.

## Test plan
- Reset seeding: after reset release, check rnd_start is high for exactly 1 cycle and rnd_ic = 16'hACE1. Randomizer q must read 16'hACE1 on the following cycle, and req_ready must rise 1 cycle after rnd_start.
- Greedy with tie: epsilon = 0, Q = {10, -5, 30, 30} → action = 2, explored = 0, act_valid at T+6 (N = 4).
- Signed greedy: epsilon = 0, Q = {-100, -3, -50, -7} → action = 1. Also Q = {32767, -32768, 0, 0} → action = 0.
- Forced explore: epsilon = 16'hFFFF and rnd at T not equal to 16'hFFFF → explored = 1, action = rnd[1:0] at T+5.
  - Repeat with epsilon = 0 and the same stimulus → explored = 0.
- Backpressure: hold act_ready = 0 for 10 cycles → action and explored stay stable and req_ready stays 0. Raise act_ready → req_ready = 1 in the next cycle.
- Mid-scan reset: assert rst_n = 0 at T+2 → all outputs return to reset values immediately, with no act_valid. The reseed pulse recurs after release, and the next request completes normally.
